// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module  : icache_refill
// Brief   : ICache line refill engine. Reads a BLOCK_SIZE-byte line one byte
//           at a time through the shared RAM arbiter and returns the whole line
//           with a one-cycle memDataValid pulse. Defining
//           ICACHE_REFILL_PREFETCH_EN enables next-line prefetch.
// Rev     : 1.0
// ============================================================================
module icache_refill #(
   parameter int ADDR_WIDTH  = 17,
   parameter int BLOCK_WIDTH = 4,
   parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
   input  logic                               clkIn,
   input  logic                               resetIn,
   input  logic                               missIn,
   input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0]  missAddrIn,
   input  logic                               flushIn,
   input  logic                               memGrantIn,
   input  logic [7:0]                         memByteIn,
   output logic                               memReqOut,
   output logic                               memReadEnOut,
   output logic [ADDR_WIDTH-1:0]              memAddrOut,
   output logic                               memDataValid,
   output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0]  memAddr,
   output logic [BLOCK_SIZE*8-1:0]            memDataOut,
   output logic                               busyOut
);

   localparam int BASE_WIDTH = ADDR_WIDTH - BLOCK_WIDTH;
   localparam int CNT_WIDTH  = BLOCK_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] c_blockSize = CNT_WIDTH'(BLOCK_SIZE);
   localparam logic [CNT_WIDTH-1:0] c_lastIdx   = CNT_WIDTH'(BLOCK_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2,
      COOL  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_nextState;
   logic [BASE_WIDTH-1:0]     r_base;
   logic [BASE_WIDTH-1:0]     w_startBase;
   logic [CNT_WIDTH-1:0]      r_issueCnt;
   logic [CNT_WIDTH-1:0]      r_recvCnt;
   logic                      r_pending;
   logic [BLOCK_SIZE*8-1:0]   r_line;
   logic [BLOCK_SIZE*8-1:0]   w_lineNext;
   logic                      w_readEn;
   logic                      w_start;
   logic                      w_kill;
   logic                      w_abort;
`ifdef ICACHE_REFILL_PREFETCH_EN
   logic                      r_prefetch;
   logic                      w_startPf;

   // A demand miss on a different block takes priority over a speculative fetch.
   assign w_abort = r_prefetch && missIn && (missAddrIn != r_base);
`else
   assign w_abort = 1'b0;
`endif

   assign w_readEn     = (r_state == FETCH) && memGrantIn && (r_issueCnt < c_blockSize);
   assign memReqOut    = (r_state == FETCH);
   assign memReadEnOut = w_readEn;
   assign memAddrOut   = (r_state == FETCH) ? {r_base, r_issueCnt[BLOCK_WIDTH-1:0]} : '0;
   assign memDataValid = (r_state == DONE);
   assign busyOut      = (r_state != IDLE);

   always_comb begin
      w_lineNext = r_line;
      if (r_pending) begin
         w_lineNext[{r_recvCnt[BLOCK_WIDTH-1:0], 3'b000} +: 8] = memByteIn;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_startBase = missAddrIn;
      w_kill      = 1'b0;
`ifdef ICACHE_REFILL_PREFETCH_EN
      w_startPf   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (missIn && !flushIn) begin
               w_nextState = FETCH;
               w_start     = 1'b1;
            end
         end
         FETCH: begin
            if (flushIn || w_abort) begin
               w_nextState = IDLE;
               w_kill      = 1'b1;
            end else if (r_pending && (r_recvCnt == c_lastIdx)) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = COOL;
         end
         COOL: begin
            w_nextState = IDLE;
`ifdef ICACHE_REFILL_PREFETCH_EN
            if (!missIn && !flushIn && !r_prefetch) begin
               w_nextState = FETCH;
               w_start     = 1'b1;
               w_startBase = r_base + BASE_WIDTH'(1);
               w_startPf   = 1'b1;
            end
`endif
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_issueCnt <= '0;
         r_recvCnt  <= '0;
         r_pending  <= 1'b0;
         r_line     <= '0;
         memAddr    <= '0;
         memDataOut <= '0;
`ifdef ICACHE_REFILL_PREFETCH_EN
         r_prefetch <= 1'b0;
`endif
      end else begin
         r_state <= w_nextState;
         if (w_start) begin
            r_base     <= w_startBase;
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
            r_pending  <= 1'b0;
`ifdef ICACHE_REFILL_PREFETCH_EN
            r_prefetch <= w_startPf;
`endif
         end else if (w_kill) begin
            // Any byte still in flight is dropped along with the counters.
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
            r_pending  <= 1'b0;
`ifdef ICACHE_REFILL_PREFETCH_EN
            r_prefetch <= 1'b0;
`endif
         end else if (r_state == FETCH) begin
            r_pending <= w_readEn;
            if (w_readEn) begin
               r_issueCnt <= r_issueCnt + CNT_WIDTH'(1);
            end
            if (r_pending) begin
               r_line    <= w_lineNext;
               r_recvCnt <= r_recvCnt + CNT_WIDTH'(1);
            end
            if (w_nextState == DONE) begin
               memAddr    <= r_base;
               memDataOut <= w_lineNext;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_refill
// Brief   : Directed self-checking bench for icache_refill with a byte RAM
//           model returning addr[7:0] one cycle after each read.
// Rev     : 1.0
// ============================================================================
module tb_icache_refill;

   localparam int ADDR_WIDTH  = 17;
   localparam int BLOCK_WIDTH = 4;
   localparam int BLOCK_SIZE  = 16;
   localparam int BASE_WIDTH  = ADDR_WIDTH - BLOCK_WIDTH;

   logic                    clkIn = 1'b0;
   logic                    resetIn;
   logic                    missIn;
   logic [BASE_WIDTH-1:0]   missAddrIn;
   logic                    flushIn;
   logic                    memGrantIn;
   logic [7:0]              memByteIn = 8'hEE;
   logic                    memReqOut;
   logic                    memReadEnOut;
   logic [ADDR_WIDTH-1:0]   memAddrOut;
   logic                    memDataValid;
   logic [BASE_WIDTH-1:0]   memAddr;
   logic [BLOCK_SIZE*8-1:0] memDataOut;
   logic                    busyOut;

   icache_refill #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .BLOCK_SIZE  (BLOCK_SIZE)
   ) dut (
      .clkIn        (clkIn),
      .resetIn      (resetIn),
      .missIn       (missIn),
      .missAddrIn   (missAddrIn),
      .flushIn      (flushIn),
      .memGrantIn   (memGrantIn),
      .memByteIn    (memByteIn),
      .memReqOut    (memReqOut),
      .memReadEnOut (memReadEnOut),
      .memAddrOut   (memAddrOut),
      .memDataValid (memDataValid),
      .memAddr      (memAddr),
      .memDataOut   (memDataOut),
      .busyOut      (busyOut)
   );

   always #5 clkIn = ~clkIn;

   int cyc = 0;
   always @(posedge clkIn) cyc = cyc + 1;

   int                    testsRun    = 0;
   int                    testsFailed = 0;
   logic [ADDR_WIDTH-1:0] rdAddr[$];
   int                    rdCyc[$];
   int                    validCount = 0;
   int                    validCyc   = 0;
   logic [BASE_WIDTH-1:0] vAddr      = '0;
   logic [127:0]          vData      = '0;

   // Observation of reads and line returns, mid-cycle.
   always @(negedge clkIn) begin
      if (memReadEnOut === 1'b1) begin
         rdAddr.push_back(memAddrOut);
         rdCyc.push_back(cyc);
      end
      if (memDataValid === 1'b1) begin
         validCount = validCount + 1;
         validCyc   = cyc;
         vAddr      = memAddr;
         vData      = memDataOut;
      end
   end

   // Byte RAM: data for a read issued in cycle k is presented during cycle k+1.
   logic                  ramRd;
   logic [ADDR_WIDTH-1:0] ramAddr;
   always begin
      @(negedge clkIn);
      ramRd   = (memReadEnOut === 1'b1);
      ramAddr = memAddrOut;
      @(posedge clkIn);
      #1;
      memByteIn = ramRd ? ramAddr[7:0] : 8'hEE;
   end

   task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      testsRun = testsRun + 1;
      if (got !== exp) begin
         testsFailed = testsFailed + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkIn);
      #2;
   endtask

   task automatic sampleNeg();
      @(negedge clkIn);
      #1;
   endtask

   task automatic doReset();
      resetIn    = 1'b0;
      missIn     = 1'b0;
      flushIn    = 1'b0;
      memGrantIn = 1'b1;
      missAddrIn = '0;
      repeat (2) tick();
      resetIn = 1'b1;
      tick();
   endtask

   task automatic waitValid(input int startCount, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         sampleNeg();
         if (validCount > startCount) ok = 1'b1;
      end
   endtask

   task automatic waitReads(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         sampleNeg();
         if (rdAddr.size() >= target) ok = 1'b1;
      end
   endtask

   task automatic checkReads(input string tag, input int rb, input logic [ADDR_WIDTH-1:0] first);
      int n;
      logic [ADDR_WIDTH-1:0] got;
      logic [ADDR_WIDTH-1:0] exp;
      n   = rdAddr.size() - rb;
      got = first;
      exp = first;
      checkEq({tag, "_count"}, 128'(n), 128'd16);
      for (int i = 0; i < n && i < 16; i++) begin
         if (rdAddr[rb+i] !== first + ADDR_WIDTH'(i)) begin
            got = rdAddr[rb+i];
            exp = first + ADDR_WIDTH'(i);
            break;
         end
      end
      checkEq({tag, "_addrs"}, 128'(got), 128'(exp));
   endtask

   localparam logic [127:0] LINE_12 = 128'h2F2E2D2C2B2A29282726252423222120;
   localparam logic [127:0] LINE_13 = 128'h3F3E3D3C3B3A39383736353433323130;
   localparam logic [127:0] LINE_40 = 128'h0F0E0D0C0B0A09080706050403020100;

   initial begin
      int rb;
      int vb;
      int lat;
      bit ok;

      // Reset state, with a miss already presented.
      resetIn    = 1'b0;
      missIn     = 1'b1;
      missAddrIn = 13'h012;
      flushIn    = 1'b0;
      memGrantIn = 1'b1;
      repeat (2) tick();
      checkEq("rst_busy",  128'(busyOut),      128'd0);
      checkEq("rst_req",   128'(memReqOut),    128'd0);
      checkEq("rst_rden",  128'(memReadEnOut), 128'd0);
      checkEq("rst_raddr", 128'(memAddrOut),   128'd0);
      checkEq("rst_valid", 128'(memDataValid), 128'd0);
      checkEq("rst_maddr", 128'(memAddr),      128'd0);
      checkEq("rst_data",  memDataOut,         128'd0);

      // Basic refill with continuous grant.
      doReset();
      rb = rdAddr.size();
      vb = validCount;
      missAddrIn = 13'h012;
      missIn     = 1'b1;
      waitValid(vb, 40, ok);
      missIn = 1'b0;
      checkEq("t1_valid_seen", 128'(ok), 128'd1);
      checkReads("t1", rb, 17'h120);
      checkEq("t1_maddr", 128'(vAddr), 128'h012);
      checkEq("t1_data",  vData,       LINE_12);
      lat = (rdCyc.size() > rb) ? validCyc - rdCyc[rb] : -1;
      checkEq("t1_latency", 128'(lat), 128'd17);
      lat = (rdCyc.size() > rb + 15) ? rdCyc[rb+15] - rdCyc[rb] : -1;
      checkEq("t1_consecutive", 128'(lat), 128'd15);
      repeat (2) sampleNeg();
      checkEq("t1_one_pulse", 128'(validCount - vb), 128'd1);

      // Grant withdrawn for 3 cycles after the 5th read.
      doReset();
      rb = rdAddr.size();
      vb = validCount;
      missAddrIn = 13'h012;
      missIn     = 1'b1;
      waitReads(rb + 5, 30, ok);
      checkEq("t2_reads5", 128'(ok), 128'd1);
      tick();
      memGrantIn = 1'b0;
      sampleNeg();
      checkEq("t2_pause_addr", 128'(memAddrOut),   128'h125);
      checkEq("t2_pause_rden", 128'(memReadEnOut), 128'd0);
      repeat (3) tick();
      memGrantIn = 1'b1;
      waitValid(vb, 40, ok);
      missIn = 1'b0;
      checkEq("t2_valid_seen", 128'(ok), 128'd1);
      checkReads("t2", rb, 17'h120);
      checkEq("t2_data", vData, LINE_12);
      lat = (rdCyc.size() > rb + 5) ? rdCyc[rb+5] - rdCyc[rb+4] : -1;
      checkEq("t2_gap", 128'(lat), 128'd4);
      lat = (rdCyc.size() > rb) ? validCyc - rdCyc[rb] : -1;
      checkEq("t2_latency", 128'(lat), 128'd20);

      // Flush after 8 reads, then a fresh miss on another block.
      doReset();
      rb = rdAddr.size();
      vb = validCount;
      missAddrIn = 13'h012;
      missIn     = 1'b1;
      waitReads(rb + 8, 30, ok);
      checkEq("t3_reads8", 128'(ok), 128'd1);
      flushIn = 1'b1;
      missIn  = 1'b0;
      tick();
      flushIn = 1'b0;
      sampleNeg();
      checkEq("t3_idle_after_flush", 128'(busyOut), 128'd0);
      repeat (25) sampleNeg();
      checkEq("t3_no_valid", 128'(validCount - vb), 128'd0);
      checkEq("t3_reads_stop", 128'(rdAddr.size() - rb), 128'd8);
      rb = rdAddr.size();
      vb = validCount;
      missAddrIn = 13'h013;
      missIn     = 1'b1;
      waitValid(vb, 40, ok);
      missIn = 1'b0;
      checkEq("t3_valid_seen", 128'(ok), 128'd1);
      checkReads("t3", rb, 17'h130);
      checkEq("t3_maddr", 128'(vAddr), 128'h013);
      checkEq("t3_data",  vData,       LINE_13);

      // Miss held through DONE and COOL.
      doReset();
      rb = rdAddr.size();
      vb = validCount;
      missAddrIn = 13'h012;
      missIn     = 1'b1;
      waitValid(vb, 40, ok);
      checkEq("t4_valid_seen", 128'(ok), 128'd1);
      tick();
      sampleNeg();
      checkEq("t4_cool_busy",  128'(busyOut),      128'd1);
      checkEq("t4_cool_req",   128'(memReqOut),    128'd0);
      checkEq("t4_cool_valid", 128'(memDataValid), 128'd0);
      tick();
      missIn = 1'b0;
      sampleNeg();
      checkEq("t4_idle_busy", 128'(busyOut),   128'd0);
      checkEq("t4_idle_req",  128'(memReqOut), 128'd0);
`ifndef ICACHE_REFILL_PREFETCH_EN
      repeat (20) sampleNeg();
      checkEq("t4_one_refill", 128'(validCount - vb),    128'd1);
      checkEq("t4_one_fetch",  128'(rdAddr.size() - rb), 128'd16);

      // Asynchronous reset in the middle of a fetch, after a completed line.
      rb = rdAddr.size();
      vb = validCount;
      missAddrIn = 13'h013;
      missIn     = 1'b1;
      waitReads(rb + 4, 30, ok);
      checkEq("t5_reads4", 128'(ok), 128'd1);
      resetIn = 1'b0;
      #1;
      checkEq("t5_busy",  128'(busyOut),      128'd0);
      checkEq("t5_req",   128'(memReqOut),    128'd0);
      checkEq("t5_rden",  128'(memReadEnOut), 128'd0);
      checkEq("t5_raddr", 128'(memAddrOut),   128'd0);
      checkEq("t5_maddr", 128'(memAddr),      128'd0);
      checkEq("t5_data",  memDataOut,         128'd0);
      missIn = 1'b0;
      repeat (2) tick();
      resetIn = 1'b1;
      repeat (25) sampleNeg();
      checkEq("t5_no_valid", 128'(validCount - vb), 128'd0);
`else
      // Next-line prefetch, then a demand miss that aborts it.
      doReset();
      vb = validCount;
      missAddrIn = 13'h012;
      missIn     = 1'b1;
      waitValid(vb, 40, ok);
      missIn = 1'b0;
      checkEq("pf_first_valid", 128'(ok), 128'd1);
      rb = rdAddr.size();
      waitReads(rb + 3, 30, ok);
      checkEq("pf_started", 128'(ok), 128'd1);
      checkEq("pf_addr", 128'((rdAddr.size() > rb) ? rdAddr[rb] : '0), 128'h130);
      vb = validCount;
      missAddrIn = 13'h040;
      missIn     = 1'b1;
      waitValid(vb, 60, ok);
      missIn = 1'b0;
      checkEq("pf_abort_valid", 128'(ok),               128'd1);
      checkEq("pf_abort_maddr", 128'(vAddr),            128'h040);
      checkEq("pf_abort_data",  vData,                  LINE_40);
      checkEq("pf_abort_once",  128'(validCount - vb),  128'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Memory-side refill engine feeding the instruction cache.
- Accepts a block-miss request from the ICache and fetches the BLOCK_SIZE-byte line from byte-wide RAM through the shared memory arbiter.
- Assembles the line and returns it with a one-cycle memDataValid pulse, carrying the block address and line data, on exactly the bus the ICache consumes.

Parameters:
ADDR_WIDTH, 17, byte-address width of instruction memory
BLOCK_WIDTH, 4, log2 of line size in bytes
BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes (16)

Ports:
clkIn  input  1  system clock
resetIn  input  1  asynchronous, active-low reset
missIn  input  1  ICache miss request (level)
missAddrIn  input  ADDR_WIDTH-BLOCK_WIDTH  block address of missing line ([ADDR_WIDTH-1:BLOCK_WIDTH])
flushIn  input  1  pipeline flush; abandon current fetch
memGrantIn  input  1  arbiter grants RAM port this cycle
memByteIn  input  8  RAM read data; valid one cycle after a read was issued
memReqOut  output  1  request RAM port ownership
memReadEnOut  output  1  byte read issued this cycle
memAddrOut  output  ADDR_WIDTH  byte address of read
memDataValid  output  1  one-cycle line-ready pulse to ICache
memAddr  output  ADDR_WIDTH-BLOCK_WIDTH  block address of returned line
memDataOut  output  BLOCK_SIZE*8  line data, byte k at bits [8k+7:8k]
busyOut  output  1  state != IDLE

Behaviour:
- Reset (resetIn low, async): state=IDLE, issueCnt=recvCnt=0, pending=0.
- All outputs 0 during reset; memDataOut/memAddr cleared to 0.
- States: IDLE, FETCH, DONE, COOL.
- IDLE:
  - missIn && !flushIn at an edge: latch base=missAddrIn, clear counters, go to FETCH.
  - flushIn has priority over missIn.
- FETCH:
  - memReqOut=1.
  - memReadEnOut = memGrantIn && issueCnt<BLOCK_SIZE (combinational).
  - memAddrOut = {base, issueCnt[BLOCK_WIDTH-1:0]} whenever state=FETCH; 0 otherwise.
  - Each issued read increments issueCnt and sets pending for the next cycle; otherwise pending<=0.
  - If pending: memByteIn is written to byte recvCnt of the line buffer and recvCnt increments.
  - Capture of byte BLOCK_SIZE-1 moves the block to DONE.
  - Grant loss mid-fetch: issue stalls and issueCnt holds. The byte already in flight is still captured the following cycle.
- DONE (one cycle):
  - memDataValid=1, memAddr=base, memDataOut=line buffer; memReqOut=0.
  - Next state COOL.
- COOL (one cycle):
  - missIn ignored, giving the ICache one edge to install the line and clear its miss.
  - Next state IDLE.
- memAddr/memDataOut hold their last values outside DONE.
- Latency, grant continuously high: missIn sampled at edge E0 → reads in the 16 cycles after E0 → memDataValid in the 17th cycle after the first read cycle.
- flushIn:
  - In FETCH: next state IDLE, counters cleared, in-flight byte discarded, no memDataValid.
  - In DONE: the pulse is not suppressed, because the line is correct memory content.
  - In COOL/IDLE: no effect beyond blocking a new start.
- missIn while busy: ignored; the ICache holds missIn until served.
- Async reset mid-fetch: immediate return to IDLE, no partial line emitted.

Optional Feature:
- Macro ICACHE_REFILL_PREFETCH_EN.
- Defined: from COOL, if !missIn && !flushIn, start a fetch of block base+1 (wraps to 0 at top of address space) and mark it as prefetch.
  - In prefetch FETCH, missIn with missAddrIn != base aborts the prefetch; the new miss starts in the next cycle.
  - missIn with missAddrIn equal to the prefetched block continues the fetch.
  - A completed prefetch emits memDataValid normally; no chained prefetch follows it.
- Undefined: COOL always returns to IDLE; no speculative reads.

Test Plan:
- Reset, then missIn=1 with missAddrIn=0x012 and grant always 1 → memAddrOut 0x120..0x12F on 16 consecutive cycles. With memByteIn=addr[7:0], memDataValid pulses once with memAddr=0x012 and memDataOut=0x2F2E…2120.
- Same fetch with memGrantIn low for 3 cycles after the 5th read → issue pauses at 0x125. Byte 0x124 is still captured; the line is identical; memDataValid arrives 3 cycles later.
- flushIn asserted after 8 reads → no memDataValid. The next missIn=0x013 fetches 0x130.. from byte 0.
- missIn held high through DONE/COOL → exactly one refill; no second fetch starts before COOL ends.
- Async reset pulled low mid-FETCH (no clock edge) → all outputs 0 immediately; busyOut=0.
- PREFETCH_EN: miss 0x012 completes → block 0x013 is fetched automatically. A miss on 0x040 during that prefetch → prefetch aborted, 0x400.. fetched.
